// File: rtl/result_record_serializer.sv
// Result record serializer: buffers 64-bit {addr, data} records in a small FIFO
// and drains each one as 8 bytes, most significant byte first, over a
// valid/ready byte handshake. Dropped records are flagged by a sticky overflow.
module result_record_serializer #(
  parameter int unsigned DEPTH = 8,
  parameter bit          DEDUP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] data_in,
  input  logic        enable_in,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        fifo_full,
  output logic        overflow,
  output logic        busy,
  output logic [15:0] record_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic [63:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     rec_cnt_q, rec_cnt_d;
  logic [63:0]     last_q, last_d;
  logic            last_vld_q, last_vld_d;
  state_e          state_q, state_d;
  logic [63:0]     shreg_q, shreg_d;
  logic [2:0]      idx_q, idx_d;

  logic not_empty, hs, pop, dup, push_try, push, drop;

  // Push/pop decisions; a pop at the same edge frees a slot for a push when full.
  always_comb begin
    not_empty = (cnt_q != '0);
    hs        = (state_q == StSend) && byte_ready;
    pop       = not_empty && ((state_q == StIdle) || (hs && (idx_q == 3'd7)));
    dup       = DEDUP && last_vld_q && (data_in == last_q);
    push_try  = enable_in && !dup;
    push      = push_try && ((cnt_q != CntW'(DEPTH)) || pop);
    drop      = push_try && !push;
  end

  // FIFO bookkeeping, loss flag, accepted-record counter and dedup history.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q | drop;
    rec_cnt_d  = rec_cnt_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (push) begin
      wr_ptr_d  = wr_ptr_q + PtrW'(1);
      rec_cnt_d = rec_cnt_q + 16'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) cnt_d = cnt_q + CntW'(1);
    else if (pop && !push) cnt_d = cnt_q - CntW'(1);
    full_d = (cnt_d == CntW'(DEPTH));
    // History only survives back-to-back enable cycles; a dropped record keeps it.
    if (!enable_in) begin
      last_vld_d = 1'b0;
    end else if (push) begin
      last_d     = data_in;
      last_vld_d = 1'b1;
    end
  end

  // Serializer next state: load on pop, shift on each handshake, reload with no bubble.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StSend;
          shreg_d = mem_q[rd_ptr_q];
          idx_d   = 3'd0;
        end
      end
      StSend: begin
        if (hs) begin
          shreg_d = {shreg_q[55:0], 8'h00};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            if (pop) shreg_d = mem_q[rd_ptr_q];
            else     state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rec_cnt_q  <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      state_q    <= StIdle;
      shreg_q    <= '0;
      idx_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      rec_cnt_q  <= rec_cnt_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    byte_valid   = (state_q == StSend);
    byte_out     = byte_valid ? shreg_q[63:56] : 8'h00;
    busy         = (cnt_q != '0) || byte_valid;
    fifo_full    = full_q;
    overflow     = ovf_q;
    record_count = rec_cnt_q;
  end

endmodule

// File: tb/tb_result_record_serializer.sv
// Directed bench for result_record_serializer; a second instance with DEDUP=0
// shares the stimulus so the dedup comparison can be made side by side.
module tb_result_record_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] data_in;
  logic        enable_in;
  logic        byte_ready;
  logic [7:0]  byte_out, byte_out0;
  logic        byte_valid, byte_valid0;
  logic        fifo_full, fifo_full0;
  logic        overflow, overflow0;
  logic        busy, busy0;
  logic [15:0] record_count, record_count0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  result_record_serializer #(.DEPTH(8), .DEDUP(1'b1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enable_in(enable_in),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .fifo_full(fifo_full), .overflow(overflow), .busy(busy), .record_count(record_count)
  );

  result_record_serializer #(.DEPTH(8), .DEDUP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in), .enable_in(enable_in),
    .byte_out(byte_out0), .byte_valid(byte_valid0), .byte_ready(byte_ready),
    .fifo_full(fifo_full0), .overflow(overflow0), .busy(busy0), .record_count(record_count0)
  );

  function automatic logic [7:0] byte_of(input logic [63:0] r, input int k);
    logic [63:0] s;
    s = r >> (56 - 8 * k);
    return s[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable_in = 1'b0; data_in = '0; byte_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Let both instances run dry with ready high; expiry counts as a failure.
  task automatic drain();
    int n = 0;
    byte_ready = 1'b1;
    while ((busy || busy0) && n < 300) begin tick(); n++; end
    total++;
    if (busy || busy0) begin
      bad++; $display("FAIL drain_timeout: busy=%0b busy0=%0b required 0", busy, busy0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({byte_valid, busy, fifo_full, overflow} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b required 0000",
                      {byte_valid, busy, fifo_full, overflow});
    end
    total++;
    if (byte_out !== 8'h00 || record_count !== 16'h0) begin
      bad++; $display("FAIL reset_values: byte_out=%h count=%h required 00/0000",
                      byte_out, record_count);
    end
  endtask

  task automatic test_single();
    logic [63:0] rec = 64'h0010_0000_0000_00AB;
    do_reset();
    byte_ready = 1'b1;
    data_in = rec; enable_in = 1'b1;
    tick();                      // edge N: pushed
    enable_in = 1'b0;
    total++;
    if (byte_valid !== 1'b0) begin
      bad++; $display("FAIL single_latency: byte_valid=%b after push edge required 0", byte_valid);
    end
    tick();                      // edge N+1: popped
    for (int k = 0; k < 8; k++) begin
      total++;
      if (byte_valid !== 1'b1 || byte_out !== byte_of(rec, k)) begin
        bad++; $display("FAIL single_byte%0d: valid=%b byte=%h required 1/%h",
                        k, byte_valid, byte_out, byte_of(rec, k));
      end
      tick();
    end
    total++;
    if (byte_valid !== 1'b0 || busy !== 1'b0 || record_count !== 16'd1) begin
      bad++; $display("FAIL single_end: valid=%b busy=%b count=%0d required 0/0/1",
                      byte_valid, busy, record_count);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rec = 64'h0010_0000_0000_00AB;
    logic [3:0]  pat = 4'b1001;  // ready sequence 1,0,0,1 read from bit 3 down
    int hs = 0;
    int cyc = 0;
    do_reset();
    data_in = rec; enable_in = 1'b1;
    tick();
    enable_in = 1'b0;
    tick();
    while (cyc < 100 && !(hs == 8 && !byte_valid)) begin
      byte_ready = pat[3 - (cyc % 4)];
      if (byte_valid) begin
        total++;
        if (hs > 7 || byte_out !== byte_of(rec, hs)) begin
          bad++; $display("FAIL bp_byte: hs=%0d byte=%h required %h",
                          hs, byte_out, byte_of(rec, hs % 8));
        end
        if (byte_ready) hs++;
      end
      tick();
      cyc++;
    end
    byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (byte_valid) hs++;
      tick();
    end
    total++;
    if (hs !== 8) begin
      bad++; $display("FAIL bp_handshakes: got %0d required 8", hs);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] exp;
    int nbytes = 0;
    int cyc = 0;
    do_reset();
    byte_ready = 1'b0;
    // One record moves into the shift register, so 9 fill the FIFO and the 10th drops.
    for (int i = 1; i <= 10; i++) begin
      data_in = {16'h0030, 48'(i)}; enable_in = 1'b1;
      tick();
      if (i == 9) begin
        total++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
          bad++; $display("FAIL ovf_full: full=%b ovf=%b required 1/0", fifo_full, overflow);
        end
      end
    end
    enable_in = 1'b0;
    total++;
    if (overflow !== 1'b1 || record_count !== 16'd9) begin
      bad++; $display("FAIL ovf_drop: ovf=%b count=%0d required 1/9", overflow, record_count);
    end
    byte_ready = 1'b1;
    while (byte_valid && cyc < 200) begin
      exp = {16'h0030, 48'(nbytes / 8 + 1)};
      total++;
      if (byte_out !== byte_of(exp, nbytes % 8)) begin
        bad++; $display("FAIL ovf_stream: byte %0d got %h required %h",
                        nbytes, byte_out, byte_of(exp, nbytes % 8));
      end
      nbytes++;
      tick();
      cyc++;
    end
    total++;
    if (nbytes !== 72 || overflow !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL ovf_drain: bytes=%0d ovf=%b busy=%b required 72/1/0",
                      nbytes, overflow, busy);
    end
  endtask

  task automatic test_full_pop();
    logic [63:0] last = 64'h0040_0000_0000_00EE;
    logic [7:0]  lastb = 8'h00;
    int nbytes = 0;
    int cyc = 0;
    do_reset();
    byte_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      data_in = {16'h0040, 48'(i)}; enable_in = 1'b1;
      tick();
    end
    enable_in = 1'b0;
    byte_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (fifo_full !== 1'b1) begin
      bad++; $display("FAIL fp_prefull: full=%b required 1", fifo_full);
    end
    data_in = last; enable_in = 1'b1;
    tick();                      // byte 7 handshake, pop and push together
    enable_in = 1'b0;
    total++;
    if (overflow !== 1'b0 || fifo_full !== 1'b1 || record_count !== 16'd10) begin
      bad++; $display("FAIL fp_accept: ovf=%b full=%b count=%0d required 0/1/10",
                      overflow, fifo_full, record_count);
    end
    while (byte_valid && cyc < 200) begin
      lastb = byte_out; nbytes++;
      tick();
      cyc++;
    end
    total++;
    if (nbytes !== 72 || lastb !== 8'hEE) begin
      bad++; $display("FAIL fp_drain: bytes=%0d last=%h required 72/ee", nbytes, lastb);
    end
  endtask

  task automatic test_dedup();
    do_reset();
    byte_ready = 1'b1;
    data_in = 64'h0020_0000_0000_0005;
    enable_in = 1'b1; tick(); tick(); tick();
    enable_in = 1'b0; tick();
    enable_in = 1'b1; tick();
    enable_in = 1'b0;
    total++;
    if (record_count !== 16'd2 || overflow !== 1'b0) begin
      bad++; $display("FAIL dedup_on: count=%0d ovf=%b required 2/0", record_count, overflow);
    end
    total++;
    if (record_count0 !== 16'd4) begin
      bad++; $display("FAIL dedup_off: count=%0d required 4", record_count0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    do_reset();
    byte_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      data_in = {16'h0050, 48'(i)}; enable_in = 1'b1;
      tick();
    end
    enable_in = 1'b0;
    tick();                      // serializer now presenting byte index 3, 3 queued
    total++;
    if (byte_out !== 8'h00 || byte_valid !== 1'b1) begin
      bad++; $display("FAIL mid_pre: valid=%b byte=%h required 1/00", byte_valid, byte_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({byte_valid, busy, overflow} !== 3'b000 || record_count !== 16'd0) begin
      bad++; $display("FAIL mid_reset: vbo=%b count=%0d required 000/0",
                      {byte_valid, busy, overflow}, record_count);
    end
    for (int i = 0; i < 20; i++) begin
      if (byte_valid || busy) stale++;
      tick();
    end
    total++;
    if (stale !== 0) begin
      bad++; $display("FAIL mid_stale: %0d cycles with activity required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_dedup();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
